// File: rtl/input_port_reader_if.sv
// Processor-side bus signals of the input port reader: address, write strobe and interrupt handshake.
interface input_port_reader_if;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic       bus_interrupt_raise;
    logic       bus_interrupt_ack;

    modport master (
        output bus_addr,
        output bus_we,
        output bus_interrupt_ack,
        input  bus_interrupt_raise
    );

    modport slave (
        input  bus_addr,
        input  bus_we,
        input  bus_interrupt_ack,
        output bus_interrupt_raise
    );
endinterface

// File: rtl/input_port_reader.sv
// Debounced switch/button reader on the shared 8-bit bus with latched button presses.
// Optional interrupt support (mask register at BASE+3) is enabled by defining INPUT_PORT_IRQ_EN.
module input_port_reader #(
    parameter logic [7:0] BASE_ADDR       = 8'hE0,
    parameter int         DEBOUNCE_CYCLES = 100000,
    parameter int         TICK_WIDTH      = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    input_port_reader_if.slave   bus,
    inout  wire  [7:0]           bus_data,
    input  logic [7:0]           switches,
    input  logic [3:0]           buttons
);
    localparam int N_IN = 12;
    localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [TICK_WIDTH-1:0] tick_cnt;
    logic                  tick;
    logic [N_IN-1:0]       sync_p0, sync_p1;
    logic [N_IN-1:0]       smp0, smp1, smp2;
    logic [N_IN-1:0]       agree;
    logic [N_IN-1:0]       deb;
    logic [3:0]            btn_q;
    logic [3:0]            press;
    logic [3:0]            capt;
    logic [3:0]            clr;
    logic [7:0]            offset;
    logic                  hit, rd, wr;
    logic [7:0]            mask_rd;
    logic [7:0]            rd_mux;
    logic [7:0]            dout;
    logic                  oe;
    logic [3:0]            unused_data_hi;

    assign tick  = (tick_cnt == TICK_LAST);
    assign agree = ~(smp0 ^ smp1) & ~(smp1 ^ smp2);
    assign press = deb[11:8] & ~btn_q;

    // Offset arithmetic keeps the decode correct for bases that are not 4-aligned.
    assign offset = bus.bus_addr - BASE_ADDR;
    assign hit    = (offset[7:2] == 6'd0);
    assign rd     = hit & ~bus.bus_we;
    assign wr     = hit & bus.bus_we;
    assign clr    = (wr && offset[1:0] == 2'd2) ? bus_data[3:0] : 4'd0;
    assign unused_data_hi = bus_data[7:4];

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            sync_p0  <= '0;
            sync_p1  <= '0;
            smp0     <= '0;
            smp1     <= '0;
            smp2     <= '0;
            deb      <= '0;
            btn_q    <= '0;
            capt     <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_WIDTH'(1);
            sync_p0  <= {buttons, switches};
            sync_p1  <= sync_p0;
            if (tick) begin
                smp0 <= sync_p1;
                smp1 <= smp0;
                smp2 <= smp1;
            end
            deb   <= (deb & ~agree) | (smp0 & agree);
            btn_q <= deb[11:8];
            // A press in the same cycle as a clear of that bit keeps it set.
            capt  <= (capt & ~clr) | press;
        end
    end

`ifdef INPUT_PORT_IRQ_EN
    logic [3:0] irq_mask;
    logic [3:0] capt_q;
    logic       irq_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask    <= '0;
            capt_q      <= '0;
            irq_pending <= 1'b0;
        end else begin
            capt_q <= capt;
            if (wr && offset[1:0] == 2'd3)
                irq_mask <= bus_data[3:0];
            // Only a fresh 0->1 capture edge on an enabled bit raises; set beats ack.
            if (|(capt & ~capt_q & irq_mask))
                irq_pending <= 1'b1;
            else if (bus.bus_interrupt_ack)
                irq_pending <= 1'b0;
        end
    end

    assign bus.bus_interrupt_raise = irq_pending;
    assign mask_rd                 = {4'b0, irq_mask};
`else
    logic unused_ack;
    assign unused_ack              = bus.bus_interrupt_ack;
    assign bus.bus_interrupt_raise = 1'b0;
    assign mask_rd                 = 8'h00;
`endif

    always_comb begin
        rd_mux = 8'h00;
        case (offset[1:0])
            2'd0:    rd_mux = deb[7:0];
            2'd1:    rd_mux = {4'b0, deb[11:8]};
            2'd2:    rd_mux = {4'b0, capt};
            default: rd_mux = mask_rd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            oe <= 1'b0;
        else
            oe <= rd;
    end

    always_ff @(posedge clk) begin
        if (rd)
            dout <= rd_mux;
    end

    assign bus_data = oe ? dout : 8'hzz;
endmodule

// File: tb/tb_input_port_reader.sv
// Directed self-checking bench for input_port_reader (DEBOUNCE_CYCLES=4, TICK_WIDTH=3, BASE 0xE0).
module tb_input_port_reader;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] switches;
    logic [3:0] buttons;
    logic       tb_drv;
    logic [7:0] tb_wdata;
    wire  [7:0] bus_data;
    int         checks = 0;
    int         passes = 0;

    input_port_reader_if bus_if();

    assign bus_data = tb_drv ? tb_wdata : 8'hzz;

    input_port_reader #(
        .BASE_ADDR(8'hE0),
        .DEBOUNCE_CYCLES(4),
        .TICK_WIDTH(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if),
        .bus_data(bus_data),
        .switches(switches),
        .buttons(buttons)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic oe_seen);
        bus_if.bus_addr = a;
        bus_if.bus_we   = 1'b0;
        step();
        d       = bus_data;
        oe_seen = dut.oe;
        bus_if.bus_addr = 8'h00;
        step();
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] v);
        bus_if.bus_addr = a;
        bus_if.bus_we   = 1'b1;
        tb_wdata        = v;
        tb_drv          = 1'b1;
        step();
        bus_if.bus_we   = 1'b0;
        tb_drv          = 1'b0;
        bus_if.bus_addr = 8'h00;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       oe_seen;
        reset = 1'b1;
        wait_n(3);
        reset = 1'b0;
        checks++; if (bus_if.bus_interrupt_raise !== 1'b0) $display("FAIL reset_raise: got %b want 0", bus_if.bus_interrupt_raise); else passes++;
        checks++; if (dut.oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", dut.oe); else passes++;
        for (int i = 0; i < 4; i++) begin
            bus_read(8'hE0 + 8'(i), d, oe_seen);
            checks++; if (d !== 8'h00) $display("FAIL reset_read_%0d: got %h want 00", i, d); else passes++;
            checks++; if (oe_seen !== 1'b1) $display("FAIL reset_read_oe_%0d: got %b want 1", i, oe_seen); else passes++;
        end
        bus_read(8'hDF, d, oe_seen);
        checks++; if (oe_seen !== 1'b0) $display("FAIL oe_addr_df: got %b want 0", oe_seen); else passes++;
        bus_read(8'hE4, d, oe_seen);
        checks++; if (oe_seen !== 1'b0) $display("FAIL oe_addr_e4: got %b want 0", oe_seen); else passes++;
        bus_if.bus_addr = 8'hE0;
        bus_if.bus_we   = 1'b1;
        step();
        checks++; if (dut.oe !== 1'b0) $display("FAIL oe_on_write: got %b want 0", dut.oe); else passes++;
        bus_if.bus_we   = 1'b0;
        bus_if.bus_addr = 8'h00;
        step();
    endtask

    task automatic test_switch_debounce();
        logic [7:0] d;
        logic       oe_seen;
        switches = 8'hA5;
        wait_n(18);
        bus_read(8'hE0, d, oe_seen);
        checks++; if (d !== 8'hA5) $display("FAIL sw_stable: got %h want a5", d); else passes++;
        switches = 8'h00;
        wait_n(5);
        switches = 8'hA5;
        wait_n(20);
        bus_read(8'hE0, d, oe_seen);
        checks++; if (d !== 8'hA5) $display("FAIL sw_glitch: got %h want a5", d); else passes++;
        bus_read(8'hE1, d, oe_seen);
        checks++; if (d !== 8'h00) $display("FAIL btn_idle: got %h want 00", d); else passes++;
    endtask

    task automatic test_capture();
        logic [7:0] d;
        logic       oe_seen;
        int         n;
        buttons = 4'b0100;
        wait_n(20);
        bus_read(8'hE1, d, oe_seen);
        checks++; if (d !== 8'h04) $display("FAIL btn_held: got %h want 04", d); else passes++;
        buttons = 4'b0000;
        wait_n(20);
        bus_read(8'hE1, d, oe_seen);
        checks++; if (d !== 8'h00) $display("FAIL btn_released: got %h want 00", d); else passes++;
        bus_read(8'hE2, d, oe_seen);
        checks++; if (d !== 8'h04) $display("FAIL capt_after_release: got %h want 04", d); else passes++;
        bus_write(8'hE2, 8'h04);
        bus_read(8'hE2, d, oe_seen);
        checks++; if (d !== 8'h00) $display("FAIL capt_w1c: got %h want 00", d); else passes++;
        // Land the clear on exactly the edge that captures a new press.
        buttons = 4'b0100;
        n = 0;
        while (n < 40 && dut.press[2] !== 1'b1) begin
            step();
            n++;
        end
        checks++; if (n >= 40) $display("FAIL press_timeout: got %0d cycles want <40", n); else passes++;
        bus_write(8'hE2, 8'h04);
        step();
        bus_read(8'hE2, d, oe_seen);
        checks++; if (d !== 8'h04) $display("FAIL capt_clear_vs_press: got %h want 04", d); else passes++;
        buttons = 4'b0000;
        wait_n(20);
    endtask

`ifdef INPUT_PORT_IRQ_EN
    task automatic test_irq();
        logic [7:0] d;
        logic       oe_seen;
        logic       seen;
        int         n;
        bus_write(8'hE3, 8'h01);
        bus_read(8'hE3, d, oe_seen);
        checks++; if (d !== 8'h01) $display("FAIL mask_read: got %h want 01", d); else passes++;
        bus_write(8'hE2, 8'h0F);
        buttons = 4'b0010;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus_if.bus_interrupt_raise === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL irq_masked: got %b want 0", seen); else passes++;
        buttons = 4'b0000;
        wait_n(20);
        buttons = 4'b0001;
        n = 0;
        while (n < 40 && dut.capt[0] !== 1'b1) begin
            step();
            n++;
        end
        checks++; if (n >= 40) $display("FAIL capt0_timeout: got %0d cycles want <40", n); else passes++;
        checks++; if (bus_if.bus_interrupt_raise !== 1'b0) $display("FAIL irq_early: got %b want 0", bus_if.bus_interrupt_raise); else passes++;
        step();
        checks++; if (bus_if.bus_interrupt_raise !== 1'b1) $display("FAIL irq_raise: got %b want 1", bus_if.bus_interrupt_raise); else passes++;
        bus_if.bus_interrupt_ack = 1'b1;
        step();
        bus_if.bus_interrupt_ack = 1'b0;
        checks++; if (bus_if.bus_interrupt_raise !== 1'b0) $display("FAIL irq_ack: got %b want 0", bus_if.bus_interrupt_raise); else passes++;
        buttons = 4'b0000;
        wait_n(20);
        buttons = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus_if.bus_interrupt_raise === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL irq_recapture: got %b want 0", seen); else passes++;
        buttons = 4'b0000;
        wait_n(20);
    endtask
`else
    task automatic test_irq();
        logic [7:0] d;
        logic       oe_seen;
        logic       seen;
        bus_write(8'hE3, 8'h0F);
        bus_read(8'hE3, d, oe_seen);
        checks++; if (d !== 8'h00) $display("FAIL mask_disabled: got %h want 00", d); else passes++;
        bus_write(8'hE2, 8'h0F);
        buttons = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus_if.bus_interrupt_raise === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL irq_disabled_raise: got %b want 0", seen); else passes++;
        buttons = 4'b0000;
        wait_n(20);
        bus_read(8'hE2, d, oe_seen);
        checks++; if (d !== 8'h01) $display("FAIL capt_irq_disabled: got %h want 01", d); else passes++;
    endtask
`endif

    task automatic test_reset_mid_debounce();
        logic [7:0] d;
        logic       oe_seen;
        reset = 1'b1;
        step();
        reset   = 1'b0;
        buttons = 4'b1000;
        // Two samples are taken by the edge 8 cycles after the first reset.
        wait_n(8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus_read(8'hE1, d, oe_seen);
        checks++; if (d !== 8'h00) $display("FAIL mid_reset_cleared: got %h want 00", d); else passes++;
        wait_n(9);
        bus_read(8'hE1, d, oe_seen);
        checks++; if (d !== 8'h00) $display("FAIL mid_reset_early: got %h want 00", d); else passes++;
        bus_read(8'hE1, d, oe_seen);
        checks++; if (d !== 8'h08) $display("FAIL mid_reset_accept: got %h want 08", d); else passes++;
        buttons = 4'b0000;
    endtask

    initial begin
        reset                    = 1'b1;
        switches                 = 8'h00;
        buttons                  = 4'b0000;
        tb_drv                   = 1'b0;
        tb_wdata                 = 8'h00;
        bus_if.bus_addr          = 8'h00;
        bus_if.bus_we            = 1'b0;
        bus_if.bus_interrupt_ack = 1'b0;
        test_reset();
        test_switch_debounce();
        test_capture();
        test_irq();
        test_reset_mid_debounce();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/input_port_reader.md
# input_port_reader

Memory-mapped bus responder that samples the board slide switches and push buttons, debounces them, latches button-press events and returns all of it to the processor on bus reads. It sits on the same shared 8-bit bus as the display and timer peripherals, driving the bidirectional data lines only when the processor reads one of its own addresses. It can also raise a processor interrupt on a latched, enabled button press.

## Interface
- BASE_ADDR, 8'hE0: first of four consecutive register addresses (BASE..BASE+3).
- DEBOUNCE_CYCLES, 100000: CLK cycles between debounce sample ticks (1 ms at 100 MHz); minimum 2.
- TICK_WIDTH, 17: width of the tick counter; must satisfy 2^TICK_WIDTH ≥ DEBOUNCE_CYCLES.

Ports:
- CLK  in  1  system clock (100 MHz).
- RESET  in  1  synchronous, active-high reset.
- BUS_ADDR  in  8  bus address.
- BUS_DATA  inout  8  bus data; high-Z unless this block is answering a read.
- BUS_WE  in  1  bus write enable; 1 = write, 0 = read.
- SWITCHES  in  8  asynchronous slide-switch inputs.
- BUTTONS  in  4  asynchronous push-button inputs, active-high.
- BUS_INTERRUPT_RAISE  out  1  interrupt request to the processor.
- BUS_INTERRUPT_ACK  in  1  interrupt acknowledge from the processor.

## Operation
- Every switch and button input passes through a two-flop synchronizer.
- One shared tick counter counts 0..DEBOUNCE_CYCLES-1 and emits a one-cycle tick on wrap.
- Each input has a 3-bit sample shift register, loaded with the synchronized value on each tick.
- The debounced value changes only when all three samples agree and differ from the current debounced value.
- Press capture: capt[i] is set in the cycle the debounced BUTTONS[i] goes 0→1. Releases are ignored.
- Register map:
  - BASE+0: read = debounced switches. Writes are ignored.
  - BASE+1: read = {4'b0, debounced buttons}. Writes are ignored.
  - BASE+2: read = {4'b0, capt}. A write clears capt[i] wherever BUS_DATA[i]=1 (write-1-to-clear).
  - BASE+3: read/write = {4'b0, irq_mask}. A write stores BUS_DATA[3:0].
- Writes take effect at the clock edge where BUS_WE=1 and the address matches.
- Interrupt:
  - irq_pending is set when any capt bit rises while its irq_mask bit is 1.
  - irq_pending is cleared by BUS_INTERRUPT_ACK=1.
  - If a set event and ACK occur in the same cycle, the set wins.
  - BUS_INTERRUPT_RAISE = irq_pending.
- Boundary rules:
  - If a press and a W1C clear of the same capt bit coincide, the bit stays 1.
  - A press on a bit that is already captured does not set irq_pending again.
  - Addresses outside BASE..BASE+3 are never driven or decoded.
- Reset clears all synchronizers, shift registers, debounced values, capt, irq_mask, irq_pending and the tick counter, and releases BUS_DATA to high-Z. Reset during debouncing discards partial samples.

## Timing
- Read latency is 1 cycle. When the address matches and BUS_WE=0 at edge N, the output-data and output-enable registers load at edge N. BUS_DATA is then valid from edge N until edge N+1 re-evaluates.
- Output enable drops one cycle after the address leaves the range or BUS_WE rises.
- Input-to-debounced latency: 2 cycles of synchronization, plus 3 ticks, plus up to one tick of phase uncertainty.
- Capture: capt is updated one cycle after the debounced edge.
- Interrupt: BUS_INTERRUPT_RAISE goes high one cycle after the capt rise and goes low one cycle after ACK.
- Reset values: BUS_DATA high-Z, BUS_INTERRUPT_RAISE 0.

## Configuration
- INPUT_PORT_IRQ_EN:
  - Defined: the irq_mask register, irq_pending and interrupt behaviour are as above.
  - Undefined: BUS_INTERRUPT_RAISE is tied to 0, BUS_INTERRUPT_ACK is ignored, BASE+3 reads 8'h00 and writes to it are ignored.
  - Capture, debounce and the other registers are identical in both builds.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, TICK_WIDTH=3, BASE_ADDR=8'hE0.
- Reset value: after reset, read 0xE0, 0xE1, 0xE2 and 0xE3 → 8'h00 each, RAISE=0, and BUS_DATA is Z whenever the address is not in E0–E3 or BUS_WE=1.
- Switch debounce: SWITCHES=8'hA5 held stable → 0xE0 reads 8'hA5 within 2+4×4 cycles. A 5-cycle glitch to 8'h00 → read still 8'hA5.
- Capture and clear:
  - Press BUTTONS[2] and release it → 0xE2 reads 8'h04.
  - Write 8'h04 to 0xE2 → reads 8'h00.
  - Write 8'h04 coinciding with a new debounced press → reads 8'h04.
- Interrupt (IRQ_EN defined):
  - Write 8'h01 to 0xE3, then press BUTTONS[1] → RAISE stays 0.
  - Press BUTTONS[0] → RAISE=1 one cycle after capt[0] rises.
  - Pulse ACK → RAISE=0 next cycle. A second press with capt[0] still set → RAISE stays 0.
- IRQ_EN undefined: write 8'h0F to 0xE3 → read 8'h00. Press any button → RAISE stays 0 and capt still updates.
- Reset mid-debounce: assert RESET 2 ticks into a BUTTONS[3] change → after reset, 0xE1 reads 8'h00, and the press is then accepted only after 3 further full ticks.
